// File: rtl/io_pkg.sv
// io_pkg: shared page map, reset constants and byte-lane merge for the I/O register block.
package io_pkg;
    localparam int SW_BIT  = 16;
    localparam int PAGE_HI = 14;
    localparam int PAGE_LO = 12;
    typedef enum logic [2:0] {
        PAGE_LEDR  = 3'd0,
        PAGE_LEDG  = 3'd1,
        PAGE_HEXLO = 3'd2,
        PAGE_HEXHI = 3'd3,
        PAGE_LCD   = 3'd4
    } page_e;
    localparam logic [31:0] HEX_RESET     = 32'h7F7F7F7F;
    localparam int unsigned DB_CYCLES_DEF = 50000;
    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? wd[8*k +: 8] : old[8*k +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop switch synchronizer with optional shared-counter debounce stage.
module sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int          DB_CNT_W  = 16
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_sw,
  output logic [31:0] o_sw
);
  logic [31:0] s1, s2;
`ifdef IO_SW_DEBOUNCE_EN
  logic [31:0]         acc;
  logic [DB_CNT_W-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1  <= '0;
      s2  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      s1 <= i_sw;
      s2 <= s1;
      if (s2 == acc) cnt <= '0;
      else if (cnt >= DB_CNT_W'(DB_CYCLES - 1)) begin
        acc <= s2;
        cnt <= '0;
      end else if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  assign o_sw = acc;
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_sw;
      s2 <= s1;
    end
  end
  assign o_sw = s2;
`endif
endmodule

// File: rtl/io_peripheral.sv
// io_peripheral: memory-mapped LED/HEX/LCD registers with combinational readback and switch input.
module io_peripheral
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int          DB_CNT_W  = 16
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_io_wren,
  input  logic [31:0] i_io_addr,
  input  logic [31:0] i_io_wdata,
  input  logic [3:0]  i_io_bmask,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_rdata,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);
  logic [31:0] ledr, ledg, hexlo, hexhi, lcd, sw_acc;
  logic [2:0]  page;
  logic        sw_sel, wr;
  logic        unused_addr;
  assign page        = i_io_addr[PAGE_HI:PAGE_LO];
  assign sw_sel      = i_io_addr[SW_BIT];
  assign wr          = i_io_wren & ~sw_sel;
  assign unused_addr = ^{i_io_addr[31:17], i_io_addr[15], i_io_addr[11:0]};
  sw_debounce #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_sw (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sw   (i_io_sw),
    .o_sw   (sw_acc)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr  <= '0;
      ledg  <= '0;
      hexlo <= HEX_RESET;
      hexhi <= HEX_RESET;
      lcd   <= '0;
    end else if (wr) begin
      if (page == PAGE_LEDR)  ledr  <= merge_bytes(ledr,  i_io_wdata, i_io_bmask);
      if (page == PAGE_LEDG)  ledg  <= merge_bytes(ledg,  i_io_wdata, i_io_bmask);
      if (page == PAGE_HEXLO) hexlo <= merge_bytes(hexlo, i_io_wdata, i_io_bmask);
      if (page == PAGE_HEXHI) hexhi <= merge_bytes(hexhi, i_io_wdata, i_io_bmask);
      if (page == PAGE_LCD)   lcd   <= merge_bytes(lcd,   i_io_wdata, i_io_bmask);
    end
  end
  always_comb begin
    o_io_rdata = sw_sel ? sw_acc :
                 page == PAGE_LEDR  ? ledr  :
                 page == PAGE_LEDG  ? ledg  :
                 page == PAGE_HEXLO ? hexlo :
                 page == PAGE_HEXHI ? hexhi :
                 page == PAGE_LCD   ? lcd   : 32'h0;
  end
  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hexlo[6:0];
  assign o_io_hex1 = hexlo[14:8];
  assign o_io_hex2 = hexlo[22:16];
  assign o_io_hex3 = hexlo[30:24];
  assign o_io_hex4 = hexhi[6:0];
  assign o_io_hex5 = hexhi[14:8];
  assign o_io_hex6 = hexhi[22:16];
  assign o_io_hex7 = hexhi[30:24];
endmodule

// File: tb/tb_io_peripheral.sv
// tb_io_peripheral: table-driven register checks plus reset and switch-latency sequences.
module tb_io_peripheral;
  logic        clk = 1'b0, rst_n = 1'b1, wren = 1'b0;
  logic [31:0] addr = '0, wdata = '0, sw = '0;
  logic [3:0]  bmask = '0;
  logic [31:0] rdata, ledr, ledg, lcd;
  logic [6:0]  hx [8];
  int total = 0, bad = 0;
  logic [31:0] sb [$];
`ifdef IO_SW_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  always #5 clk = ~clk;
  io_peripheral #(.DB_CYCLES(4), .DB_CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_io_wren(wren), .i_io_addr(addr),
    .i_io_wdata(wdata), .i_io_bmask(bmask), .i_io_sw(sw), .o_io_rdata(rdata),
    .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex0(hx[0]), .o_io_hex1(hx[1]), .o_io_hex2(hx[2]), .o_io_hex3(hx[3]),
    .o_io_hex4(hx[4]), .o_io_hex5(hx[5]), .o_io_hex6(hx[6]), .o_io_hex7(hx[7]),
    .o_io_lcd(lcd)
  );
  typedef struct {
    logic        wr;
    logic [31:0] wa, wd;
    logic [3:0]  m;
    logic [31:0] ra, exp;
  } vec_t;
  vec_t v [9];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    wren = 1'b0;
    addr = a;
    #1;
    d = rdata;
  endtask
  logic [31:0] d, e;
  initial begin
    v[0] = '{1'b1, 32'h1000_0000, 32'hAABBCCDD, 4'b1111, 32'h1000_0000, 32'hAABBCCDD};
    v[1] = '{1'b1, 32'h1000_0000, 32'h00001100, 4'b0010, 32'h1000_0FFC, 32'hAABB11DD};
    v[2] = '{1'b1, 32'h1000_2004, 32'h40792430, 4'b1111, 32'h1000_2000, 32'h40792430};
    v[3] = '{1'b1, 32'h1000_1008, 32'h12345678, 4'b0101, 32'h1000_1000, 32'h00340078};
    v[4] = '{1'b1, 32'h1000_4000, 32'hCAFEBABE, 4'b1100, 32'h1000_4010, 32'hCAFE0000};
    v[5] = '{1'b1, 32'h1000_3FFC, 32'hFF818283, 4'b1000, 32'h1000_3000, 32'hFF7F7F7F};
    v[6] = '{1'b1, 32'h1001_0000, 32'hFFFFFFFF, 4'b1111, 32'h1001_0000, 32'hA5A50F0F};
    v[7] = '{1'b1, 32'h1000_5000, 32'hFFFFFFFF, 4'b1111, 32'h1000_5000, 32'h0};
    v[8] = '{1'b0, 32'h0,         32'h0,         4'b0000, 32'h1000_7000, 32'h0};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ledr_async", ledr, 32'h0);
    chk("rst_ledg_async", ledg, 32'h0);
    chk("rst_lcd_async", lcd, 32'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_hex%0d", i), {25'h0, hx[i]}, 32'h7F);
    rd(32'h1000_2000, d); chk("rst_rd_hexlo", d, 32'h7F7F7F7F);
    rd(32'h1000_3000, d); chk("rst_rd_hexhi", d, 32'h7F7F7F7F);
    tick();
    tick();
    #2 rst_n = 1'b1;
    sw = 32'hA5A50F0F;
    repeat (LAT + 4) tick();
    for (int i = 0; i < 9; i++) begin
      wren  = v[i].wr;
      addr  = v[i].wa;
      wdata = v[i].wd;
      bmask = v[i].m;
      sb.push_back(v[i].exp);
      tick();
      rd(v[i].ra, d);
      e = sb.pop_front();
      chk($sformatf("vec%0d_rd", i), d, e);
    end
    chk("ledr_out", ledr, 32'hAABB11DD);
    chk("ledg_out", ledg, 32'h00340078);
    chk("lcd_out", lcd, 32'hCAFE0000);
    chk("hex0", {25'h0, hx[0]}, 32'h30);
    chk("hex1", {25'h0, hx[1]}, 32'h24);
    chk("hex2", {25'h0, hx[2]}, 32'h79);
    chk("hex3", {25'h0, hx[3]}, 32'h40);
    for (int i = 4; i < 8; i++) chk($sformatf("hex%0d_blank", i), {25'h0, hx[i]}, 32'h7F);
    tick();
    wren = 1'b1; addr = 32'h1000_0000; wdata = 32'h11111111; bmask = 4'hF;
    #1;
    chk("same_cycle_old", rdata, 32'hAABB11DD);
    tick();
    rd(32'h1000_0000, d);
    chk("raw_new", d, 32'h11111111);
    chk("raw_ledr_out", ledr, 32'h11111111);
    sw = 32'h0;
    repeat (LAT + 4) tick();
    sw = 32'h5;
    addr = 32'h1001_0000;
    repeat (LAT - 1) tick();
    chk("sw_lat_early", rdata, 32'h0);
    tick();
    chk("sw_lat_exact", rdata, 32'h5);
`ifdef IO_SW_DEBOUNCE_EN
    sw = 32'h0;
    repeat (LAT + 4) tick();
    sw = 32'h5;
    repeat (3) tick();
    sw = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("glitch_%0d", i), rdata, 32'h0);
    end
`endif
    sw = 32'h0;
    repeat (LAT + 4) tick();
    sw = 32'h1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ledr", ledr, 32'h0);
    chk("midrst_sw", rdata, 32'h0);
    tick();
    #2 rst_n = 1'b1;
    @(negedge clk);
    #2;
    repeat (LAT - 1) tick();
    chk("midrst_sw_early", rdata, 32'h0);
    tick();
    chk("midrst_sw_exact", rdata, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
